t05_sram_arbiter: RTL
=====================

Name: t05_sram_arbiter

Overview:
Single-port SRAM scheduler for the Huffman datapath. It shares one 32-bit SRAM bus between three requesters:
- the hTree node writer (72-bit node, 3 beats)
- the hTree null-sum reader (64-bit, 2 beats)
- the codebook node reader (72-bit, 3 beats)

It splits wide transfers into word beats, arbitrates round-robin without preemption, and returns one-cycle done pulses with assembled read data.

Parameters:
NODE_BASE, 32'h3300_0000, byte base address of the node table
STRIDE_SH, 4, log2 of byte stride per node slot (16 bytes per slot)
TIMEOUT, 255, max cycles to wait for bus_ack per beat before abort (8-bit counter)

Ports:
clk  in  1  system clock
rst_n  in  1  reset; one clock; reset is synchronous and active-high
en  in  1  grant enable; low blocks new grants, in-flight transfer completes
wr_req  in  1  node write request (level)
wr_idx  in  7  node slot index
wr_data  in  72  node to write
wr_done  out  1  one-cycle pulse, write complete
nr_req  in  1  null-sum read request (level)
nr_idx  in  7  slot index
nr_data  out  64  read data {w1,w0}
nr_done  out  1  one-cycle pulse
cb_req  in  1  codebook read request (level)
cb_idx  in  7  slot index
cb_data  out  72  read data {w2[7:0],w1,w0}
cb_done  out  1  one-cycle pulse
bus_req  out  1  SRAM strobe, held until bus_ack
bus_we  out  1  1 = write
bus_addr  out  32  byte address
bus_wdata  out  32  write word
bus_rdata  in  32  read word, valid with bus_ack
bus_ack  in  1  one-cycle beat acknowledge
busy  out  1  transfer in flight
err  out  1  one-cycle pulse on timeout abort

Behaviour:
- Reset values:
  - All outputs 0: bus_req, bus_we, bus_addr, bus_wdata, done pulses, err, busy, nr_data, cb_data.
  - State IDLE, round-robin pointer = 0 (wr), beat = 0, timeout count = 0.
  - Reset mid-transfer abandons the transfer; bus_req is 0 from the next edge.
- Address mapping:
  - bus_addr = NODE_BASE + (idx << STRIDE_SH) + (beat << 2), computed at 32 bits and wrapping.
  - Write words: beat 0 = data[31:0], beat 1 = data[63:32], beat 2 = {24'b0, data[71:64]}.
- States:
  - IDLE: if en and any request is unmasked, grant the first requester at or after the pointer (order wr -> nr -> cb -> wr). Latch its idx and data and its beat count (wr 3, nr 2, cb 3), set beat = 0, go to ISSUE. busy = 1 from the next cycle.
  - ISSUE: bus_req = 1, with bus_we / bus_addr / bus_wdata for the current beat, all registered. Go to WAIT_ACK in the same cycle the strobe is first driven (bus_req asserted the cycle after the grant).
  - WAIT_ACK: hold all bus outputs stable.
    - On bus_ack: capture bus_rdata into the beat slot of the read register; reset the timeout count.
    - If beat < last: beat + 1, update the address, keep bus_req = 1 (no bubble).
    - Else: bus_req = 0, go to DONE.
    - If the count reaches TIMEOUT with no ack: bus_req = 0, err pulse, go to DONE without a done pulse. Read data is not updated on abort.
  - DONE: one-cycle done pulse for the grantee. nr_data / cb_data update in the same cycle as the pulse and hold until that requester's next completion. Pointer := grantee + 1 (mod 3). The grantee is masked for this cycle and the next, so it must drop req after seeing done. Return to IDLE.
- Latency: request is sampled at cycle 0, first bus_req at cycle 1. With ack on the first strobe cycle of every beat, a 3-beat transfer pulses done at cycle 4.
- Simultaneous requests: the round-robin pointer decides. A requester that asserts during a transfer waits; grants are never preempted.
- en low:
  - While IDLE: no grant; requests stay pending.
  - While active: the transfer completes normally.
- bus_ack outside WAIT_ACK is ignored.
- Requesters hold idx and data stable from req until done. The arbiter latches them at grant, so later changes are harmless.

Test Plan:
- Reset, then wr_req with idx = 5, data = 72'hAB_1122_3344_5566_7788, ack on each strobe cycle -> addresses 3300_0050, 0054, 0058; wdata 5566_7788, 1122_3344, 0000_00AB; wr_done at cycle 4.
- nr_req with idx = 2, ack after 3 cycles per beat, rdata 0xDEAD0000 then 0x0000BEEF -> nr_data = 64'h0000BEEF_DEAD0000, nr_done pulses once, busy low the next cycle.
- wr_req, nr_req and cb_req all asserted at once and held -> grants in order wr, nr, cb. Then re-assert wr and cb together -> wr wins (pointer = wr after cb). No done is duplicated.
- bus_ack never returned on a cb read -> bus_req drops after 255 wait cycles, err pulses once, cb_done stays 0, cb_data is unchanged, arbiter back in IDLE.
- rst_n asserted during beat 1 of a write -> bus_req = 0 and busy = 0 the next cycle, pointer = 0. A subsequent nr_req is served normally.
- en = 0 with wr_req pending -> no bus_req. en = 1 -> grant the next cycle. en dropped mid-transfer -> transfer completes and wr_done pulses.

Source files
------------

// File: rtl/t05_sram_arbiter.sv
// Single-port SRAM scheduler: round-robin, non-preemptive sharing of one 32-bit bus between
// the node writer, the null-sum reader and the codebook reader, with per-beat ack timeout.
module t05_sram_arbiter #(
   parameter logic [31:0] NODE_BASE = 32'h3300_0000,
   parameter int unsigned STRIDE_SH = 4,
   parameter int unsigned TIMEOUT   = 255
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        en,
   input  logic        wr_req,
   input  logic [6:0]  wr_idx,
   input  logic [71:0] wr_data,
   output logic        wr_done,
   input  logic        nr_req,
   input  logic [6:0]  nr_idx,
   output logic [63:0] nr_data,
   output logic        nr_done,
   input  logic        cb_req,
   input  logic [6:0]  cb_idx,
   output logic [71:0] cb_data,
   output logic        cb_done,
   output logic        bus_req,
   output logic        bus_we,
   output logic [31:0] bus_addr,
   output logic [31:0] bus_wdata,
   input  logic [31:0] bus_rdata,
   input  logic        bus_ack,
   output logic        busy,
   output logic        err
);

   typedef enum logic [1:0] {StIdle, StWaitAck, StDone} state_e;

   localparam logic [1:0] IdWr = 2'd0;
   localparam logic [1:0] IdNr = 2'd1;
   localparam logic [1:0] IdCb = 2'd2;

   state_e      state_q, state_d;
   logic [1:0]  ptr_q, ptr_d;
   logic [1:0]  gnt_q, gnt_d;
   logic [1:0]  beat_q, beat_d;
   logic [1:0]  last_q, last_d;
   logic [7:0]  cnt_q, cnt_d;
   logic [6:0]  idx_q, idx_d;
   logic [71:0] wdat_q, wdat_d;
   logic [63:0] rd_q, rd_d;
   logic        mask_q, mask_d;
   logic        bus_req_q, bus_req_d;
   logic        bus_we_q, bus_we_d;
   logic [31:0] bus_addr_q, bus_addr_d;
   logic [31:0] bus_wdata_q, bus_wdata_d;
   logic        wr_done_q, wr_done_d;
   logic        nr_done_q, nr_done_d;
   logic        cb_done_q, cb_done_d;
   logic        err_q, err_d;
   logic [63:0] nr_data_q, nr_data_d;
   logic [71:0] cb_data_q, cb_data_d;

   logic [3:0]  req_v;
   logic [1:0]  cand;
   logic [1:0]  sel;
   logic        found;
   logic [6:0]  sel_idx;

   function automatic logic [31:0] beat_addr(input logic [6:0] idx, input logic [1:0] beat);
      beat_addr = NODE_BASE + (32'(idx) << STRIDE_SH) + (32'(beat) << 2);
   endfunction

   function automatic logic [31:0] beat_word(input logic [71:0] d, input logic [1:0] beat);
      case (beat)
         2'd0:    beat_word = d[31:0];
         2'd1:    beat_word = d[63:32];
         default: beat_word = {24'b0, d[71:64]};
      endcase
   endfunction

   always_comb begin
      // The previous grantee is ignored for one IDLE cycle so it can drop its request.
      req_v = {1'b0, cb_req, nr_req, wr_req};
      if (mask_q) req_v[gnt_q] = 1'b0;
      found = 1'b0;
      sel   = ptr_q;
      cand  = ptr_q;
      for (int k = 0; k < 3; k++) begin
         if (!found && req_v[cand]) begin
            found = 1'b1;
            sel   = cand;
         end
         cand = (cand == IdCb) ? IdWr : cand + 2'd1;
      end
      case (sel)
         IdWr:    sel_idx = wr_idx;
         IdNr:    sel_idx = nr_idx;
         default: sel_idx = cb_idx;
      endcase
   end

   always_comb begin
      state_d     = state_q;
      ptr_d       = ptr_q;
      gnt_d       = gnt_q;
      beat_d      = beat_q;
      last_d      = last_q;
      cnt_d       = cnt_q;
      idx_d       = idx_q;
      wdat_d      = wdat_q;
      rd_d        = rd_q;
      mask_d      = 1'b0;
      bus_req_d   = bus_req_q;
      bus_we_d    = bus_we_q;
      bus_addr_d  = bus_addr_q;
      bus_wdata_d = bus_wdata_q;
      wr_done_d   = 1'b0;
      nr_done_d   = 1'b0;
      cb_done_d   = 1'b0;
      err_d       = 1'b0;
      nr_data_d   = nr_data_q;
      cb_data_d   = cb_data_q;

      case (state_q)
         StIdle: begin
            if (en && found) begin
               gnt_d       = sel;
               idx_d       = sel_idx;
               wdat_d      = (sel == IdWr) ? wr_data : 72'b0;
               last_d      = (sel == IdNr) ? 2'd1 : 2'd2;
               beat_d      = 2'd0;
               cnt_d       = 8'd0;
               bus_req_d   = 1'b1;
               bus_we_d    = (sel == IdWr);
               bus_addr_d  = beat_addr(sel_idx, 2'd0);
               bus_wdata_d = (sel == IdWr) ? wr_data[31:0] : 32'b0;
               state_d     = StWaitAck;
            end
         end
         StWaitAck: begin
            if (bus_ack) begin
               cnt_d = 8'd0;
               if (beat_q == 2'd0) rd_d[31:0] = bus_rdata;
               else if (beat_q == 2'd1) rd_d[63:32] = bus_rdata;
               if (beat_q != last_q) begin
                  beat_d      = beat_q + 2'd1;
                  bus_addr_d  = beat_addr(idx_q, beat_q + 2'd1);
                  bus_wdata_d = beat_word(wdat_q, beat_q + 2'd1);
               end else begin
                  bus_req_d = 1'b0;
                  bus_we_d  = 1'b0;
                  state_d   = StDone;
                  case (gnt_q)
                     IdWr: wr_done_d = 1'b1;
                     IdNr: begin
                        nr_done_d = 1'b1;
                        nr_data_d = {bus_rdata, rd_q[31:0]};
                     end
                     default: begin
                        cb_done_d = 1'b1;
                        cb_data_d = {bus_rdata[7:0], rd_q};
                     end
                  endcase
               end
            end else if (cnt_q == 8'(TIMEOUT - 1)) begin
               bus_req_d = 1'b0;
               bus_we_d  = 1'b0;
               err_d     = 1'b1;
               state_d   = StDone;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         StDone: begin
            ptr_d   = (gnt_q == IdCb) ? IdWr : gnt_q + 2'd1;
            mask_d  = 1'b1;
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst_n) begin
         state_q     <= StIdle;
         ptr_q       <= IdWr;
         gnt_q       <= IdWr;
         beat_q      <= 2'd0;
         last_q      <= 2'd0;
         cnt_q       <= 8'd0;
         idx_q       <= 7'd0;
         wdat_q      <= 72'b0;
         rd_q        <= 64'b0;
         mask_q      <= 1'b0;
         bus_req_q   <= 1'b0;
         bus_we_q    <= 1'b0;
         bus_addr_q  <= 32'b0;
         bus_wdata_q <= 32'b0;
         wr_done_q   <= 1'b0;
         nr_done_q   <= 1'b0;
         cb_done_q   <= 1'b0;
         err_q       <= 1'b0;
         nr_data_q   <= 64'b0;
         cb_data_q   <= 72'b0;
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         gnt_q       <= gnt_d;
         beat_q      <= beat_d;
         last_q      <= last_d;
         cnt_q       <= cnt_d;
         idx_q       <= idx_d;
         wdat_q      <= wdat_d;
         rd_q        <= rd_d;
         mask_q      <= mask_d;
         bus_req_q   <= bus_req_d;
         bus_we_q    <= bus_we_d;
         bus_addr_q  <= bus_addr_d;
         bus_wdata_q <= bus_wdata_d;
         wr_done_q   <= wr_done_d;
         nr_done_q   <= nr_done_d;
         cb_done_q   <= cb_done_d;
         err_q       <= err_d;
         nr_data_q   <= nr_data_d;
         cb_data_q   <= cb_data_d;
      end
   end

   assign bus_req   = bus_req_q;
   assign bus_we    = bus_we_q;
   assign bus_addr  = bus_addr_q;
   assign bus_wdata = bus_wdata_q;
   assign wr_done   = wr_done_q;
   assign nr_done   = nr_done_q;
   assign cb_done   = cb_done_q;
   assign err       = err_q;
   assign nr_data   = nr_data_q;
   assign cb_data   = cb_data_q;
   assign busy      = (state_q != StIdle);

endmodule
